// File: rtl/ins_enc_pkg.sv
// ins_encoder shared types: RV32 opcode constants, format enum
// and the opcode-to-format lookup.
package ins_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPV    = 7'b1010111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e op_fmt(input logic [6:0] op);
    fmt_e f;
    unique case (1'b1)
      (op == OP_LOAD) || (op == OP_OPIMM) ||
      (op == OP_JALR) || (op == OP_SYSTEM): f = FMT_I;
      (op == OP_STORE):                     f = FMT_S;
      (op == OP_BRANCH):                    f = FMT_B;
      (op == OP_LUI) || (op == OP_AUIPC):   f = FMT_U;
      (op == OP_JAL):                       f = FMT_J;
      (op == OP_OP) || (op == OP_OPV):      f = FMT_R;
      default:                              f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ins_enc_pack.sv
// Combinational RV32 field packer with immediate range check;
// immediate placement mirrors the decode-side extraction.
module ins_enc_pack
  import ins_enc_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  fmt_e fmt;
  logic fit_i;
  logic fit_b;
  logic fit_j;

  assign fmt   = op_fmt(opcode);
  assign fit_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit_b = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit_j = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (fmt)
      FMT_I: begin
        word    = {imm[11:0], rs1, funct3, rd, opcode};
        illegal = !fit_i;
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, funct3,
                   imm[4:0], opcode};
        illegal = !fit_i;
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3,
                   imm[4:1], imm[11], opcode};
        illegal = !fit_b || imm[0];
      end
      FMT_U: begin
        word    = {imm[31:12], rd, opcode};
        illegal = |imm[11:0];
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11],
                   imm[19:12], rd, opcode};
        illegal = !fit_j || imm[0];
      end
      FMT_R: begin
        word    = {funct7, rs2, rs1, funct3, rd, opcode};
        illegal = 1'b0;
      end
      default: begin
        word    = {25'b0, opcode};
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ins_encoder.sv
// Instruction encoder: packer feeding a DEPTH-entry output FIFO.
// INS_ENCODER_DROP_ILLEGAL_EN: swallow illegal requests instead of queueing them.
module ins_encoder
  import ins_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic             enc_flush_in,
  input  logic             enc_valid_in,
  output logic             enc_ready_out,
  input  logic [6:0]       enc_opcode_in,
  input  logic [4:0]       enc_rd_in,
  input  logic [4:0]       enc_rs1_in,
  input  logic [4:0]       enc_rs2_in,
  input  logic [2:0]       enc_funct3_in,
  input  logic [6:0]       enc_funct7_in,
  input  logic [31:0]      enc_imm_in,
  output logic             enc_valid_out,
  input  logic             enc_ready_in,
  output logic [31:0]      enc_word_out,
  output logic             enc_illegal_out,
  output logic [CNT_W-1:0] enc_count_out,
  output logic [7:0]       enc_illegal_cnt_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pk_word;
  logic             pk_ill;
  logic             acc;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       ill_cnt_q;
  logic [31:0]      word_q [DEPTH];

  ins_enc_pack u_pack (
    .opcode  (enc_opcode_in),
    .rd      (enc_rd_in),
    .rs1     (enc_rs1_in),
    .rs2     (enc_rs2_in),
    .funct3  (enc_funct3_in),
    .funct7  (enc_funct7_in),
    .imm     (enc_imm_in),
    .word    (pk_word),
    .illegal (pk_ill)
  );

  assign enc_ready_out = reset_n_in && !enc_flush_in &&
                         (count_q < CNT_W'(DEPTH));
  assign acc           = enc_valid_in && enc_ready_out;
  assign enc_valid_out = (count_q != '0);
  assign pop           = enc_valid_out && enc_ready_in &&
                         !enc_flush_in;
  assign enc_word_out  = enc_valid_out ? word_q[rd_ptr] : '0;
  assign enc_count_out = count_q;
  assign enc_illegal_cnt_out = ill_cnt_q;

`ifdef INS_ENCODER_DROP_ILLEGAL_EN
  assign push            = acc && !pk_ill;
  assign enc_illegal_out = 1'b0;
`else
  logic ill_q [DEPTH];

  assign push            = acc;
  assign enc_illegal_out = enc_valid_out && ill_q[rd_ptr];

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ill_q <= '{default: 1'b0};
    end else if (push) begin
      ill_q[wr_ptr] <= pk_ill;
    end
  end
`endif

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      word_q <= '{default: '0};
    end else if (push) begin
      word_q[wr_ptr] <= pk_word;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (enc_flush_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Counts accepted illegal requests, including ones that were dropped
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ill_cnt_q <= '0;
    end else if (acc && pk_ill && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_q <= ill_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// Directed bench for ins_encoder: vector table plus FIFO
// backpressure, flush, saturation and reset sequences.
module tb_ins_encoder;
  import ins_enc_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef INS_ENCODER_DROP_ILLEGAL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             vin;
  logic             rdy_out;
  logic [6:0]       op;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [31:0]      imm;
  logic             vout;
  logic             rdy_in;
  logic [31:0]      word;
  logic             ill;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       ill_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_ic = 0;

  ins_encoder #(.DEPTH(DEPTH)) dut (
    .clock_in            (clk),
    .reset_n_in          (rst_n),
    .enc_flush_in        (flush),
    .enc_valid_in        (vin),
    .enc_ready_out       (rdy_out),
    .enc_opcode_in       (op),
    .enc_rd_in           (rd),
    .enc_rs1_in          (rs1),
    .enc_rs2_in          (rs2),
    .enc_funct3_in       (f3),
    .enc_funct7_in       (f7),
    .enc_imm_in          (imm),
    .enc_valid_out       (vout),
    .enc_ready_in        (rdy_in),
    .enc_word_out        (word),
    .enc_illegal_out     (ill),
    .enc_count_out       (cnt),
    .enc_illegal_cnt_out (ill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op  = v.op;
    rd  = v.rd;
    rs1 = v.rs1;
    rs2 = v.rs2;
    f3  = v.f3;
    f7  = v.f7;
    imm = v.imm;
  endtask

  function automatic logic [31:0] opimm_word(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  task automatic drive_opimm(input int k);
    op  = OP_OPIMM;
    rd  = 5'(k);
    rs1 = 5'd0;
    rs2 = 5'd0;
    f3  = 3'd0;
    f7  = 7'd0;
    imm = 32'(k);
  endtask

  task automatic push_n(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      drive_opimm(k);
      vin = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    vin = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vecs[1]  = '{OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
                 32'd8, 32'h00208463, 1'b0};
    vecs[2]  = '{OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
                 32'd7, 32'h00208363, 1'b1};
    vecs[3]  = '{OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h800, 32'h001000EF, 1'b0};
    vecs[4]  = '{OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h12345000, 32'h123452B7, 1'b0};
    vecs[5]  = '{OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h800, 32'h80000093, 1'b1};
    vecs[6]  = '{OP_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,
                 32'h0, 32'h402081B3, 1'b0};
    vecs[7]  = '{OP_STORE, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0,
                 32'hFFFFFFFC, 32'hFE512E23, 1'b0};
    vecs[8]  = '{7'h7F, 5'd1, 5'd3, 5'd4, 3'd7, 7'h7F,
                 32'd5, 32'h0000007F, 1'b1};
    vecs[9]  = '{OP_AUIPC, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h00001001, 32'h00001017, 1'b1};
    vecs[10] = '{OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'h3, 32'h0020006F, 1'b1};
    vecs[11] = '{OP_JALR, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0,
                 32'hFFFFF800, 32'h800280E7, 1'b0};

    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; rdy_in = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0;
    f3 = '0; f7 = '0; imm = '0;
    #2;
    check("rst_valid", vout, 0);
    check("rst_word", word, 0);
    check("rst_ill", ill, 0);
    check("rst_count", cnt, 0);
    check("rst_illcnt", ill_cnt, 0);
    check("rst_ready", rdy_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: one push, check head one cycle later, pop
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      vin = 1'b1;
      check($sformatf("v%0d_ready", i), rdy_out, 1);
      @(posedge clk);
      @(negedge clk);
      vin = 1'b0;
      if (vecs[i].ill) exp_ic++;
      if (DROP && vecs[i].ill) begin
        check($sformatf("v%0d_dropped", i), vout, 0);
      end else begin
        check($sformatf("v%0d_valid", i), vout, 1);
        check($sformatf("v%0d_word", i), word, vecs[i].word);
        check($sformatf("v%0d_ill", i), ill,
              DROP ? 1'b0 : vecs[i].ill);
      end
      check($sformatf("v%0d_illcnt", i), ill_cnt, exp_ic);
      rdy_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rdy_in = 1'b0;
      check($sformatf("v%0d_empty", i), cnt, 0);
    end

    // Backpressure: five offers into a four-entry FIFO
    rdy_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive_opimm(k);
      vin = 1'b1;
      check($sformatf("full_rdy%0d", k), rdy_out, k <= DEPTH);
      @(posedge clk);
    end
    @(negedge clk);
    vin = 1'b0;
    check("full_count", cnt, 4);
    check("full_ready", rdy_out, 0);
    for (int r = 0; r < 2; r++) begin
      check($sformatf("full_head%0d", r), word, opimm_word(1));
      @(negedge clk);
    end
    rdy_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_v%0d", k), vout, 1);
      check($sformatf("drain_w%0d", k), word, opimm_word(k));
      @(posedge clk);
      @(negedge clk);
    end
    rdy_in = 1'b0;
    check("drain_count", cnt, 0);
    check("drain_valid", vout, 0);

    // Push and pop in the same cycle at count 2
    push_n(2);
    check("pp_count0", cnt, 2);
    drive_opimm(3);
    vin = 1'b1;
    rdy_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    check("pp_count1", cnt, 2);
    for (int k = 2; k <= 3; k++) begin
      check($sformatf("pp_w%0d", k), word, opimm_word(k));
      @(posedge clk);
      @(negedge clk);
    end
    rdy_in = 1'b0;
    check("pp_empty", cnt, 0);

    // Flush at count 3 with a coincident pop request
    push_n(3);
    check("fl_count0", cnt, 3);
    flush = 1'b1;
    rdy_in = 1'b1;
    #1;
    check("fl_ready", rdy_out, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    rdy_in = 1'b0;
    check("fl_count", cnt, 0);
    check("fl_valid", vout, 0);
    check("fl_illcnt", ill_cnt, exp_ic);

    // Illegal counter saturation
    drive(vecs[8]);
    vin = 1'b1;
    rdy_in = 1'b1;
    repeat (260) @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    check("sat_illcnt", ill_cnt, 255);
    @(posedge clk);
    @(negedge clk);
    rdy_in = 1'b0;
    check("sat_empty", cnt, 0);

    // Asynchronous reset in the middle of a drain
    push_n(3);
    rdy_in = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_valid", vout, 0);
    check("mr_word", word, 0);
    check("mr_ill", ill, 0);
    check("mr_count", cnt, 0);
    check("mr_illcnt", ill_cnt, 0);
    check("mr_ready", rdy_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_in = 1'b0;
    @(negedge clk);
    drive_opimm(7);
    vin = 1'b1;
    check("mr_nvalid0", vout, 0);
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    check("mr_nvalid1", vout, 1);
    check("mr_nword", word, opimm_word(7));
    check("mr_ncount", cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
